// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   optype_e : op class of an instruction, as produced by the decoder
//   fwd_e    : ID-stage operand source select
//   op_writes: true for op classes whose rd can be a forwarding source
package hazard_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_ALU   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_STORE = 2'b11
   } optype_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_LD  = 2'b11
   } fwd_e;

   // Store and none leave no register result behind, so they never match.
   function automatic logic op_writes(input optype_e op);
      return (op == OP_ALU) || (op == OP_LOAD);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage decode inputs and stage-control outputs of the
// hazard controller.
//   ID side : rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, optype_ID,
//             branch_ID, mem_busy
//   outputs : PC_EN_IF, reg_*_EN, reg_FD_flush, reg_DE_flush, fwd_A, fwd_B,
//             stall_cnt
// master = pipeline side (drives decode), slave = hazard_ctrl.
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int NREG_BITS = 5,
   parameter int CNT_W     = 16
);
   logic [NREG_BITS-1:0] rs1_ID;
   logic [NREG_BITS-1:0] rs2_ID;
   logic [NREG_BITS-1:0] rd_ID;
   logic                 rs1use_ID;
   logic                 rs2use_ID;
   optype_e              optype_ID;
   logic                 branch_ID;
   logic                 mem_busy;

   logic                 PC_EN_IF;
   logic                 reg_FD_EN;
   logic                 reg_DE_EN;
   logic                 reg_EM_EN;
   logic                 reg_MW_EN;
   logic                 reg_FD_flush;
   logic                 reg_DE_flush;
   fwd_e                 fwd_A;
   fwd_e                 fwd_B;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, optype_ID,
             branch_ID, mem_busy,
      input  PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
             reg_FD_flush, reg_DE_flush, fwd_A, fwd_B, stall_cnt
   );

   modport slave (
      input  rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, optype_ID,
             branch_ID, mem_busy,
      output PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
             reg_FD_flush, reg_DE_flush, fwd_A, fwd_B, stall_cnt
   );
endinterface

// File: rtl/fwd_sel.sv
// fwd_sel: combinational forwarding select for one ID-stage source operand.
//   rs, rs_use        : source address and whether it is read
//   rd_ex, op_ex      : producer currently in EX
//   rd_mem, op_mem    : producer currently in MEM
//   sel               : operand source
//   load_use          : source depends on a load still in EX
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int NREG_BITS = 5
) (
   input  logic [NREG_BITS-1:0] rs,
   input  logic                 rs_use,
   input  logic [NREG_BITS-1:0] rd_ex,
   input  optype_e              op_ex,
   input  logic [NREG_BITS-1:0] rd_mem,
   input  optype_e              op_mem,
   output fwd_e                 sel,
   output logic                 load_use
);

   logic hit_ex;
   logic hit_mem;

   always_comb begin
      sel      = FWD_RF;
      load_use = 1'b0;
      hit_ex   = (rs == rd_ex)  && op_writes(op_ex);
      hit_mem  = (rs == rd_mem) && op_writes(op_mem);

      // x0 is hardwired, so it is never forwarded even if a producer names it.
      if (rs_use && (rs != '0)) begin
         if (hit_ex) begin
            // Load data is not available until MEM: stall, regfile for now.
            if (op_ex == OP_ALU) sel = FWD_EX;
            else                 load_use = 1'b1;
         end else if (hit_mem) begin
            sel = (op_mem == OP_LOAD) ? FWD_LD : FWD_MEM;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core with
// branches resolved in ID.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : hazard_ctrl_if slave (decode inputs, enables, flushes,
//                forwarding selects, load-use stall counter)
// Tracks rd/op of the instructions in EX and MEM; all outputs are
// combinational from that state and the current ID inputs.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NREG_BITS = 5,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave bus
);

   logic [NREG_BITS-1:0] rd_ex_q,  rd_ex_d;
   logic [NREG_BITS-1:0] rd_mem_q, rd_mem_d;
   optype_e              op_ex_q,  op_ex_d;
   optype_e              op_mem_q, op_mem_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;

   logic lu_a, lu_b, load_use;
   fwd_e sel_a, sel_b;

   fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_a (
      .rs       (bus.rs1_ID),
      .rs_use   (bus.rs1use_ID),
      .rd_ex    (rd_ex_q),
      .op_ex    (op_ex_q),
      .rd_mem   (rd_mem_q),
      .op_mem   (op_mem_q),
      .sel      (sel_a),
      .load_use (lu_a)
   );

   fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_b (
      .rs       (bus.rs2_ID),
      .rs_use   (bus.rs2use_ID),
      .rd_ex    (rd_ex_q),
      .op_ex    (op_ex_q),
      .rd_mem   (rd_mem_q),
      .op_mem   (op_mem_q),
      .sel      (sel_b),
      .load_use (lu_b)
   );

   assign load_use  = lu_a | lu_b;
   assign bus.fwd_A = sel_a;
   assign bus.fwd_B = sel_b;
   assign bus.stall_cnt = cnt_q;

   // Stage control: memory wait freezes everything, load-use holds IF/ID
   // and bubbles EX (a branch seen with stale operands is ignored), a taken
   // branch only squashes the fetched instruction.
   always_comb begin
      bus.PC_EN_IF     = 1'b1;
      bus.reg_FD_EN    = 1'b1;
      bus.reg_DE_EN    = 1'b1;
      bus.reg_EM_EN    = 1'b1;
      bus.reg_MW_EN    = 1'b1;
      bus.reg_FD_flush = 1'b0;
      bus.reg_DE_flush = 1'b0;
      if (bus.mem_busy) begin
         bus.PC_EN_IF  = 1'b0;
         bus.reg_FD_EN = 1'b0;
         bus.reg_DE_EN = 1'b0;
         bus.reg_EM_EN = 1'b0;
         bus.reg_MW_EN = 1'b0;
      end else if (load_use) begin
         bus.PC_EN_IF     = 1'b0;
         bus.reg_FD_EN    = 1'b0;
         bus.reg_DE_flush = 1'b1;
      end else if (bus.branch_ID) begin
         bus.reg_FD_flush = 1'b1;
      end
   end

   always_comb begin
      rd_ex_d  = rd_ex_q;
      op_ex_d  = op_ex_q;
      rd_mem_d = rd_mem_q;
      op_mem_d = op_mem_q;
      cnt_d    = cnt_q;
      if (!bus.mem_busy) begin
         rd_mem_d = rd_ex_q;
         op_mem_d = op_ex_q;
         if (load_use) begin
            rd_ex_d = '0;
            op_ex_d = OP_NONE;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end else begin
            rd_ex_d = bus.rd_ID;
            op_ex_d = bus.optype_ID;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ex_q  <= '0;
         op_ex_q  <= OP_NONE;
         rd_mem_q <= '0;
         op_mem_q <= OP_NONE;
         cnt_q    <= '0;
      end else begin
         rd_ex_q  <= rd_ex_d;
         op_ex_q  <= op_ex_d;
         rd_mem_q <= rd_mem_d;
         op_mem_q <= op_mem_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int NB = 5;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_if #(.NREG_BITS(NB), .CNT_W(CW)) hif ();

   hazard_ctrl #(.NREG_BITS(NB), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hif)
   );

   always #5 clk = ~clk;

   // en = {PC_EN_IF, FD, DE, EM, MW}, fl = {FD_flush, DE_flush}
   localparam logic [4:0] EN_ALL = 5'b11111;
   localparam logic [4:0] EN_LU  = 5'b00111;
   localparam logic [4:0] EN_OFF = 5'b00000;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic id(input int rs1, input int rs2, input int rd,
                     input logic u1, input logic u2, input optype_e op,
                     input logic br, input logic busy);
      hif.rs1_ID    = rs1[NB-1:0];
      hif.rs2_ID    = rs2[NB-1:0];
      hif.rd_ID     = rd[NB-1:0];
      hif.rs1use_ID = u1;
      hif.rs2use_ID = u2;
      hif.optype_ID = op;
      hif.branch_ID = br;
      hif.mem_busy  = busy;
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] en,
                          input logic [1:0] fl, input fwd_e fa, input fwd_e fb);
      logic [10:0] obs, exp;
      obs = {hif.PC_EN_IF, hif.reg_FD_EN, hif.reg_DE_EN, hif.reg_EM_EN,
             hif.reg_MW_EN, hif.reg_FD_flush, hif.reg_DE_flush,
             hif.fwd_A, hif.fwd_B};
      exp = {en, fl, fa, fb};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int exp);
      checks++;
      assert (hif.stall_cnt === exp[CW-1:0]) else begin
         errors++;
         $error("FAIL %s observed=%0d required=%0d", tag, hif.stall_cnt, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      // Reset state, with ID inputs that would hazard on non-reset state.
      id(5, 5, 5, 1, 1, OP_LOAD, 0, 0);
      chk_ctl("reset_outputs", EN_ALL, 2'b00, FWD_RF, FWD_RF);
      chk_cnt("reset_cnt", 0);
      #3 rst_n = 1'b1;

      // addi x1 ; add x2,x1,x3 ; sub x4,x1,x1
      id(0, 0, 1, 1, 0, OP_ALU, 0, 0);
      chk_ctl("addi_idle", EN_ALL, 2'b00, FWD_RF, FWD_RF);
      tick();
      id(1, 3, 2, 1, 1, OP_ALU, 0, 0);
      chk_ctl("fwd_ex", EN_ALL, 2'b00, FWD_EX, FWD_RF);
      tick();
      id(1, 1, 4, 1, 1, OP_ALU, 0, 0);
      chk_ctl("fwd_mem_both", EN_ALL, 2'b00, FWD_MEM, FWD_MEM);
      tick();
      // EX=x4, MEM=x2: EX and MEM sources in one instruction, writes x0
      id(4, 2, 0, 1, 1, OP_ALU, 0, 0);
      chk_ctl("fwd_ex_mem", EN_ALL, 2'b00, FWD_EX, FWD_MEM);
      tick();
      // EX=x0 ALU, MEM=x4: x0 never forwards, unused source ignored
      id(0, 4, 0, 1, 0, OP_NONE, 0, 0);
      chk_ctl("x0_and_unused", EN_ALL, 2'b00, FWD_RF, FWD_RF);
      tick();
      // store naming rd=7 never becomes a source
      id(0, 0, 7, 1, 1, OP_STORE, 0, 0);
      tick();
      id(7, 0, 0, 1, 0, OP_NONE, 0, 0);
      chk_ctl("store_ex_nomatch", EN_ALL, 2'b00, FWD_RF, FWD_RF);
      tick();
      chk_ctl("store_mem_nomatch", EN_ALL, 2'b00, FWD_RF, FWD_RF);

      // jal x1 with no hazard
      id(0, 0, 1, 0, 0, OP_ALU, 1, 0);
      chk_ctl("jal_flush", EN_ALL, 2'b10, FWD_RF, FWD_RF);
      tick();

      // lw x5 ; beq x5,x6 taken
      id(0, 0, 5, 1, 0, OP_LOAD, 0, 0);
      tick();
      id(5, 6, 0, 1, 1, OP_NONE, 1, 0);
      chk_ctl("load_use_stall", EN_LU, 2'b01, FWD_RF, FWD_RF);
      tick();
      chk_cnt("cnt_after_stall", 1);
      chk_ctl("after_stall_ld", EN_ALL, 2'b10, FWD_LD, FWD_RF);
      tick();

      // lw x6 ; add x8,x6 with memory busy for 3 cycles
      id(0, 0, 6, 1, 0, OP_LOAD, 0, 0);
      tick();
      id(6, 0, 8, 1, 0, OP_ALU, 0, 1);
      for (int i = 0; i < 3; i++) begin
         chk_ctl("busy_freeze", EN_OFF, 2'b00, FWD_RF, FWD_RF);
         chk_cnt("busy_cnt_hold", 1);
         tick();
      end
      id(6, 0, 8, 1, 0, OP_ALU, 0, 0);
      chk_ctl("busy_then_stall", EN_LU, 2'b01, FWD_RF, FWD_RF);
      tick();
      chk_cnt("cnt_after_busy_stall", 2);
      chk_ctl("busy_stall_once", EN_ALL, 2'b00, FWD_LD, FWD_RF);
      tick();
      // EX=x8 ALU: a busy edge must keep it in EX
      id(8, 0, 0, 1, 0, OP_NONE, 0, 1);
      tick();
      id(8, 0, 0, 1, 0, OP_NONE, 0, 0);
      chk_ctl("busy_holds_ex", EN_ALL, 2'b00, FWD_EX, FWD_RF);
      tick();

      // lw x9 ; reader, then reset mid-stall
      id(0, 0, 9, 1, 0, OP_LOAD, 0, 0);
      tick();
      id(9, 9, 0, 1, 1, OP_NONE, 1, 0);
      chk_ctl("pre_reset_stall", EN_LU, 2'b01, FWD_RF, FWD_RF);
      rst_n = 1'b0;
      #1;
      chk_ctl("async_reset_out", EN_ALL, 2'b10, FWD_RF, FWD_RF);
      chk_cnt("async_reset_cnt", 0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // saturation: 16 load-use stalls on a 4-bit counter
      for (int i = 0; i < 16; i++) begin
         id(0, 0, 5, 1, 0, OP_LOAD, 0, 0);
         tick();
         id(0, 5, 0, 0, 1, OP_NONE, 0, 0);
         if (i == 15) chk_ctl("sat_still_stalls", EN_LU, 2'b01, FWD_RF, FWD_RF);
         tick();
         if (i == 14) chk_cnt("cnt_reaches_15", 15);
      end
      chk_cnt("cnt_saturated", 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
